cgra_conf_reader_pe_wide: RTL

//  Per-PE configuration decoder for parametrised CGRAs: snoops the shared 64-bit config bus, filters by PE_ID or broadcast,

---
 rtl/cgra_conf_pkg.sv | 34 +++
 rtl/cgra_conf_const_asm.sv | 101 ++++++++++
 rtl/cgra_conf_reader_pe_wide.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/cgra_conf_pkg.sv
// Shared config-bus definitions for the CGRA configuration tree.
// Holds the command type codes, the broadcast id, the bus field positions
// and the constant-assembler state encoding. Imported by every PE reader
// and by the host-side config writer.
package cgra_conf_pkg;

  typedef enum logic [7:0] {
    CMD_NOP      = 8'd0,
    CMD_INSTR    = 8'd1,
    CMD_CONST    = 8'd2,
    CMD_PC_MAX   = 8'd3,
    CMD_PC_LOOP  = 8'd4,
    CMD_IGNORE   = 8'd5,
    CMD_QTD_LOW  = 8'd6,
    CMD_QTD_HIGH = 8'd7,
    CMD_CONST_HI = 8'd8
  } cmd_type_e;

  localparam logic [15:0] BCAST_ID = 16'hFFFF;

  localparam int TYPE_LSB    = 0;
  localparam int ID_LSB      = 8;
  localparam int THREAD_LSB  = 24;
  localparam int IADDR_LSB   = 28;
  localparam int CADDR_LSB   = 28;
  localparam int PAYLOAD_LSB = 32;
  localparam int INSTR_LSB   = 40;

  typedef enum logic {
    CA_IDLE,
    CA_WAIT_HI
  } const_state_e;

endpackage

// File: rtl/cgra_conf_const_asm.sv
// Two-beat constant assembler for constants wider than 32 bits.
// state      | meaning
// CA_IDLE    | no partial constant held
// CA_WAIT_HI | CONST beat latched (low word, addr, thread), waiting for CONST_HI
// Ports: clk/rst (async active-low); match_i/type_i/addr_i/thread_i/payload_i
// are the decoded stage-1 command; fire_o is the combinational write request
// with data_o/addr_o/thread_o; seq_err_o is the sticky protocol-error flag.
module cgra_conf_const_asm
  import cgra_conf_pkg::*;
#(
  parameter int DATA_W       = 64,
  parameter int CONST_ADDR_W = 4,
  parameter int THREAD_W     = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    match_i,
  input  logic [7:0]              type_i,
  input  logic [CONST_ADDR_W-1:0] addr_i,
  input  logic [THREAD_W-1:0]     thread_i,
  input  logic [31:0]             payload_i,
  output logic                    fire_o,
  output logic [DATA_W-1:0]       data_o,
  output logic [CONST_ADDR_W-1:0] addr_o,
  output logic [THREAD_W-1:0]     thread_o,
  output logic                    seq_err_o
);

  const_state_e              state_q, state_d;
  logic [31:0]               low_q, low_d;
  logic [CONST_ADDR_W-1:0]   addr_q, addr_d;
  logic [THREAD_W-1:0]       thr_q, thr_d;
  logic                      seq_err_q, seq_err_d;
  logic                      is_const, is_hi;

  assign is_const = match_i && (type_i == CMD_CONST);
  assign is_hi    = match_i && (type_i == CMD_CONST_HI);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= CA_IDLE;
      low_q     <= '0;
      addr_q    <= '0;
      thr_q     <= '0;
      seq_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      low_q     <= low_d;
      addr_q    <= addr_d;
      thr_q     <= thr_d;
      seq_err_q <= seq_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    low_d     = low_q;
    addr_d    = addr_q;
    thr_d     = thr_q;
    seq_err_d = seq_err_q;
    fire_o    = 1'b0;
    case (state_q)
      CA_IDLE: begin
        if (is_const) begin
          low_d   = payload_i;
          addr_d  = addr_i;
          thr_d   = thread_i;
          state_d = CA_WAIT_HI;
        end else if (is_hi) begin
          seq_err_d = 1'b1;
        end
      end
      CA_WAIT_HI: begin
        if (is_hi) begin
          fire_o  = 1'b1;
          state_d = CA_IDLE;
        end else if (match_i) begin
          // Partial constant is abandoned; a fresh CONST restarts the pair.
          seq_err_d = 1'b1;
          if (is_const) begin
            low_d  = payload_i;
            addr_d = addr_i;
            thr_d  = thread_i;
          end else begin
            state_d = CA_IDLE;
          end
        end
      end
      default: state_d = CA_IDLE;
    endcase
  end

  assign data_o    = {payload_i[DATA_W-33:0], low_q};
  assign addr_o    = addr_q;
  assign thread_o  = thr_q;
  assign seq_err_o = seq_err_q;

  logic unused_pay;
  assign unused_pay = ^payload_i;

endmodule

// File: rtl/cgra_conf_reader_pe_wide.sv
// Per-PE configuration reader. Snoops the shared 64-bit config bus, keeps
// commands addressed to PE_ID or broadcast, and issues one-cycle write
// strobes with aligned data two edges after the command is sampled.
// Ports: clk, rst (async active-low), conf_valid/conf_bus_in (bus);
// *_we strobes with their addr/data outputs for instruction memory, const
// memory, pc_max/pc_loop, ignore and qtd registers; thread_id of the current
// strobe; sticky seq_err; conf_count of accepted commands.
module cgra_conf_reader_pe_wide
  import cgra_conf_pkg::*;
#(
  parameter logic [15:0] PE_ID  = 16'd0,
  parameter int DATA_W       = 16,
  parameter int INST_W       = 16,
  parameter int INST_ADDR_W  = 1,
  parameter int CONST_ADDR_W = 4,
  parameter int PC_W         = 1,
  parameter int THREAD_W     = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    conf_valid,
  input  logic [63:0]             conf_bus_in,
  output logic                    instruction_we,
  output logic [INST_ADDR_W-1:0]  instruction_addr,
  output logic [INST_W-1:0]       instruction_data,
  output logic                    const_we,
  output logic [CONST_ADDR_W-1:0] const_waddr,
  output logic [DATA_W-1:0]       const_data,
  output logic                    pc_max_we,
  output logic                    pc_loop_we,
  output logic [PC_W-1:0]         pc_max,
  output logic [PC_W-1:0]         pc_loop,
  output logic                    ignore_we,
  output logic [DATA_W-1:0]       ignore_data,
  output logic                    qtd_we_low,
  output logic                    qtd_we_high,
  output logic [31:0]             qtd_low,
  output logic [31:0]             qtd_high,
  output logic [THREAD_W-1:0]     thread_id,
  output logic                    seq_err,
  output logic [15:0]             conf_count
);

  localparam bit WIDE = (DATA_W > 32);

  // Stage 1: raw bus capture.
  logic        valid_q;
  logic [63:0] bus_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      bus_q   <= '0;
    end else begin
      valid_q <= conf_valid;
      bus_q   <= conf_bus_in;
    end
  end

  logic [7:0]              typ;
  logic [15:0]             id;
  logic [31:0]             payload;
  logic [63:0]             pay_ext;
  logic [THREAD_W-1:0]     thr;
  logic [CONST_ADDR_W-1:0] caddr;
  logic                    type_legal, match;
  logic                    is_instr, is_pcmax, is_pcloop, is_ign, is_qlo, is_qhi;

  assign typ     = bus_q[TYPE_LSB +: 8];
  assign id      = bus_q[ID_LSB +: 16];
  assign payload = bus_q[PAYLOAD_LSB +: 32];
  assign pay_ext = {32'd0, payload};
  assign thr     = bus_q[THREAD_LSB +: THREAD_W];
  assign caddr   = bus_q[CADDR_LSB +: CONST_ADDR_W];

  // CONST_HI only exists when constants need a second beat.
  assign type_legal = ((typ >= 8'd1) && (typ <= 8'd7)) || (WIDE && (typ == CMD_CONST_HI));
  assign match      = valid_q && ((id == PE_ID) || (id == BCAST_ID)) && type_legal;

  assign is_instr  = match && (typ == CMD_INSTR);
  assign is_pcmax  = match && (typ == CMD_PC_MAX);
  assign is_pcloop = match && (typ == CMD_PC_LOOP);
  assign is_ign    = match && (typ == CMD_IGNORE);
  assign is_qlo    = match && (typ == CMD_QTD_LOW);
  assign is_qhi    = match && (typ == CMD_QTD_HIGH);

  logic                    c_fire;
  logic [DATA_W-1:0]       c_data;
  logic [CONST_ADDR_W-1:0] c_addr;
  logic [THREAD_W-1:0]     c_thr;
  logic                    seq_err_w;

  generate
    if (WIDE) begin : g_wide
      cgra_conf_const_asm #(
        .DATA_W      (DATA_W),
        .CONST_ADDR_W(CONST_ADDR_W),
        .THREAD_W    (THREAD_W)
      ) u_const_asm (
        .clk      (clk),
        .rst      (rst),
        .match_i  (match),
        .type_i   (typ),
        .addr_i   (caddr),
        .thread_i (thr),
        .payload_i(payload),
        .fire_o   (c_fire),
        .data_o   (c_data),
        .addr_o   (c_addr),
        .thread_o (c_thr),
        .seq_err_o(seq_err_w)
      );
    end else begin : g_narrow
      assign c_fire    = match && (typ == CMD_CONST);
      assign c_data    = pay_ext[DATA_W-1:0];
      assign c_addr    = caddr;
      assign c_thr     = thr;
      assign seq_err_w = 1'b0;
    end
  endgenerate

  // Stage 2: registered strobes and held data.
  logic                    instr_we_q, const_we_q, pcmax_we_q, pcloop_we_q;
  logic                    ign_we_q, qlo_we_q, qhi_we_q;
  logic [INST_ADDR_W-1:0]  iaddr_q;
  logic [INST_W-1:0]       idata_q;
  logic [CONST_ADDR_W-1:0] caddr_q;
  logic [DATA_W-1:0]       cdata_q, ign_q;
  logic [PC_W-1:0]         pcmax_q, pcloop_q;
  logic [31:0]             qlo_q, qhi_q;
  logic [THREAD_W-1:0]     thread_q;
  logic [15:0]             count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_we_q  <= 1'b0;
      const_we_q  <= 1'b0;
      pcmax_we_q  <= 1'b0;
      pcloop_we_q <= 1'b0;
      ign_we_q    <= 1'b0;
      qlo_we_q    <= 1'b0;
      qhi_we_q    <= 1'b0;
      iaddr_q     <= '0;
      idata_q     <= '0;
      caddr_q     <= '0;
      cdata_q     <= '0;
      ign_q       <= '0;
      pcmax_q     <= '0;
      pcloop_q    <= '0;
      qlo_q       <= '0;
      qhi_q       <= '0;
      thread_q    <= '0;
      count_q     <= '0;
    end else begin
      instr_we_q  <= is_instr;
      const_we_q  <= c_fire;
      pcmax_we_q  <= is_pcmax;
      pcloop_we_q <= is_pcloop;
      ign_we_q    <= is_ign;
      qlo_we_q    <= is_qlo;
      qhi_we_q    <= is_qhi;
      if (is_instr) begin
        iaddr_q <= bus_q[IADDR_LSB +: INST_ADDR_W];
        idata_q <= bus_q[INSTR_LSB +: INST_W];
      end
      if (c_fire) begin
        caddr_q <= c_addr;
        cdata_q <= c_data;
      end
      if (is_pcmax)  pcmax_q  <= payload[PC_W-1:0];
      if (is_pcloop) pcloop_q <= payload[PC_W-1:0];
      if (is_ign)    ign_q    <= pay_ext[DATA_W-1:0];
      if (is_qlo)    qlo_q    <= payload;
      if (is_qhi)    qhi_q    <= payload;
      // A wide constant reports the thread of its CONST beat, not CONST_HI.
      if (c_fire)
        thread_q <= c_thr;
      else if (is_instr | is_pcmax | is_pcloop | is_ign | is_qlo | is_qhi)
        thread_q <= thr;
      if (match) count_q <= count_q + 16'd1;
    end
  end

  assign instruction_we   = instr_we_q;
  assign instruction_addr = iaddr_q;
  assign instruction_data = idata_q;
  assign const_we         = const_we_q;
  assign const_waddr      = caddr_q;
  assign const_data       = cdata_q;
  assign pc_max_we        = pcmax_we_q;
  assign pc_loop_we       = pcloop_we_q;
  assign pc_max           = pcmax_q;
  assign pc_loop          = pcloop_q;
  assign ignore_we        = ign_we_q;
  assign ignore_data      = ign_q;
  assign qtd_we_low       = qlo_we_q;
  assign qtd_we_high      = qhi_we_q;
  assign qtd_low          = qlo_q;
  assign qtd_high         = qhi_q;
  assign thread_id        = thread_q;
  assign seq_err          = seq_err_w;
  assign conf_count       = count_q;

  logic unused_bits;
  assign unused_bits = ^{bus_q, pay_ext};

endmodule
